// File: rtl/gcd_pkg.sv
// Shared types and constants for the binary (Stein) GCD engine.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;
  localparam int GCD_SHW   = $clog2(GCD_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    ZCHK,
    TZA,
    TZB,
    SUB,
    NORM,
    DONE
  } gcd_state_e;

endpackage

// File: rtl/gcd_stein_ctrl_tzn16.sv
// tzn16: combinational 16-bit trailing-zero counter.
// The count is the index of the lowest set bit. For an all-zero input the
// count is 0 and all_zeros is raised.
module tzn16 (
  input  logic [15:0] d,
  output logic [3:0]  count,
  output logic        all_zeros
);

  // Scan from MSB down so the lowest set bit wins.
  always_comb begin
    count = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (d[i]) count = 4'(i);
    end
    all_zeros = ~|d;
  end

endmodule

// File: rtl/gcd_stein_ctrl.sv
// gcd_stein_ctrl: binary (Stein) GCD engine with valid/ready handshakes.
// A single tzn16 instance is time-shared between the TZA, TZB and NORM
// steps. The subtractor and shifters are inline.
// Optional feature macro: GCD_STEIN_CYCLE_CNT_EN adds cycles_o, which counts
// cycles from operand accept to entry into DONE (saturating at 255).
module gcd_stein_ctrl
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] gcd_o
`ifdef GCD_STEIN_CYCLE_CNT_EN
  ,
  output logic [7:0]       cycles_o
`endif
);

  if (WIDTH != GCD_WIDTH) begin : g_width_chk
    $error("gcd_stein_ctrl: WIDTH must be 16");
  end

  gcd_state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic [GCD_SHW-1:0] ka_q, k_q;
  logic               sel_q;

  logic [WIDTH-1:0]   tz_in;
  logic [GCD_SHW-1:0] tz_cnt;
  logic [GCD_SHW-1:0] tz_shift;
  logic               tz_zero;
  logic [GCD_SHW-1:0] k_min;
  logic               accept;

  tzn16 u_tzn16 (
    .d         (tz_in),
    .count     (tz_cnt),
    .all_zeros (tz_zero)
  );

  // Zero input never reaches the counter in practice; clamping keeps the shift defined anyway.
  assign tz_shift = tz_zero ? '0 : tz_cnt;
  assign k_min    = (ka_q < tz_shift) ? ka_q : tz_shift;
  assign accept   = in_valid_i && in_ready_o;
  assign gcd_o    = res_q;

  // Route the operand being normalised in this step into the shared counter.
  always_comb begin
    tz_in = '0;
    case (state_q)
      TZA:     tz_in = a_q;
      TZB:     tz_in = b_q;
      NORM:    tz_in = sel_q ? b_q : a_q;
      default: tz_in = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = ZCHK;
      end
      ZCHK: begin
        if ((a_q == '0) || (b_q == '0)) state_d = DONE;
        else                            state_d = TZA;
      end
      TZA:  state_d = TZB;
      TZB:  state_d = SUB;
      SUB: begin
        if (a_q == b_q) state_d = DONE;
        else            state_d = NORM;
      end
      NORM: state_d = SUB;
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch, trailing-zero strip, subtract and final rescale.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      ka_q  <= '0;
      k_q   <= '0;
      sel_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q <= a_i;
            b_q <= b_i;
          end
        end
        ZCHK: begin
          if ((a_q == '0) || (b_q == '0)) res_q <= a_q | b_q;
        end
        TZA: begin
          a_q  <= a_q >> tz_shift;
          ka_q <= tz_shift;
        end
        TZB: begin
          b_q <= b_q >> tz_shift;
          k_q <= k_min;
        end
        SUB: begin
          if (a_q == b_q) begin
            res_q <= a_q << k_q;
          end else if (a_q > b_q) begin
            a_q   <= a_q - b_q;
            sel_q <= 1'b0;
          end else begin
            b_q   <= b_q - a_q;
            sel_q <= 1'b1;
          end
        end
        NORM: begin
          if (sel_q) b_q <= b_q >> tz_shift;
          else       a_q <= a_q >> tz_shift;
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_STEIN_CYCLE_CNT_EN
  logic [7:0] cyc_q;
  assign cycles_o = cyc_q;

  // Accept counts as the first cycle; every busy cycle after it adds one, saturating.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= 8'd0;
    end else if (accept) begin
      cyc_q <= 8'd1;
    end else if ((state_q != IDLE) && (state_q != DONE) && (cyc_q != 8'hFF)) begin
      cyc_q <= cyc_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_stein_ctrl.sv
// Directed self-checking bench for gcd_stein_ctrl.
module tb_gcd_stein_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] gcd;
`ifdef GCD_STEIN_CYCLE_CNT_EN
  logic [7:0]  cycles;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  gcd_stein_ctrl #(.WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .gcd_o       (gcd)
`ifdef GCD_STEIN_CYCLE_CNT_EN
    ,
    .cycles_o    (cycles)
`endif
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Euclid reference, independent of the binary algorithm in the DUT.
  function automatic logic [15:0] ref_gcd(input logic [15:0] x_in, input logic [15:0] y_in);
    logic [15:0] x, y, t;
    x = x_in;
    y = y_in;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Present an operand pair from a negedge until it is taken on a rising edge.
  task automatic do_accept(input logic [15:0] av, input logic [15:0] bv);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count negedges until out_valid appears, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid || lat >= 80) break;
    end
  endtask

  // Take the result from a negedge and return at the next negedge.
  task automatic retire;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    end
    tests_run++;
    if (gcd !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_gcd got=%h want=0000", gcd);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    do_accept(16'd48, 16'd18);
    wait_done(lat);
    tests_run++;
    if (!(out_valid === 1'b1 && lat <= 68)) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency got=%0d valid=%b want<=68", lat, out_valid);
    end
    tests_run++;
    if (gcd !== 16'd6) begin
      tests_failed++;
      $display("[TB] FAIL basic_48_18 got=%0d want=6", gcd);
    end
    retire();
  endtask

  task automatic test_zero_operand;
    int lat;
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic [15:0] ve [2];
    va = '{16'd0, 16'd0};
    vb = '{16'd35, 16'd0};
    ve = '{16'd35, 16'd0};
    for (int i = 0; i < 2; i++) begin
      do_accept(va[i], vb[i]);
      wait_done(lat);
      tests_run++;
      if (!(out_valid === 1'b1 && lat == 2)) begin
        tests_failed++;
        $display("[TB] FAIL zero_latency_%0d got=%0d valid=%b want=2", i, lat, out_valid);
      end
      tests_run++;
      if (gcd !== ve[i]) begin
        tests_failed++;
        $display("[TB] FAIL zero_result_%0d got=%0d want=%0d", i, gcd, ve[i]);
      end
      retire();
    end
  endtask

  task automatic test_boundaries;
    int lat;
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic [15:0] ve [2];
    va = '{16'h8000, 16'hFFFF};
    vb = '{16'h4000, 16'hFFFF};
    ve = '{16'h4000, 16'hFFFF};
    for (int i = 0; i < 2; i++) begin
      do_accept(va[i], vb[i]);
      wait_done(lat);
      tests_run++;
      if (!(out_valid === 1'b1 && gcd === ve[i])) begin
        tests_failed++;
        $display("[TB] FAIL boundary_%0d got=%h valid=%b want=%h", i, gcd, out_valid, ve[i]);
      end
      retire();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    do_accept(16'd65535, 16'd65534);
    wait_done(lat);
    tests_run++;
    if (!(out_valid === 1'b1 && gcd === 16'd1)) begin
      tests_failed++;
      $display("[TB] FAIL bp_result got=%0d valid=%b want=1", gcd, out_valid);
    end
    in_valid = 1'b1;
    a = 16'd9;
    b = 16'd6;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (!(out_valid === 1'b1 && gcd === 16'd1 && in_ready === 1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_%0d got valid=%b gcd=%0d ready=%b want 1/1/0", i, out_valid, gcd, in_ready);
      end
    end
    in_valid = 1'b0;
    retire();
    tests_run++;
    if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL bp_retire got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    do_accept(16'd1071, 16'd462);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (!(in_ready === 1'b1 && out_valid === 1'b0 && gcd === 16'd0)) begin
      tests_failed++;
      $display("[TB] FAIL midreset got ready=%b valid=%b gcd=%0d want 1/0/0", in_ready, out_valid, gcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_accept(16'd12, 16'd8);
    wait_done(lat);
    tests_run++;
    if (!(out_valid === 1'b1 && gcd === 16'd4)) begin
      tests_failed++;
      $display("[TB] FAIL after_reset got=%0d valid=%b want=4", gcd, out_valid);
    end
    retire();
    do_accept(16'd1071, 16'd462);
    wait_done(lat);
    tests_run++;
    if (!(out_valid === 1'b1 && gcd === 16'd21)) begin
      tests_failed++;
      $display("[TB] FAIL gcd_1071_462 got=%0d valid=%b want=21", gcd, out_valid);
    end
    retire();
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [15:0] na, nb, exp_g;
    na = 16'($urandom_range(1, 65535));
    nb = 16'($urandom_range(1, 65535));
    exp_g = ref_gcd(na, nb);
    do_accept(na, nb);
    for (int i = 0; i < 100; i++) begin
      wait_done(lat);
      tests_run++;
      if (!(out_valid === 1'b1 && gcd === exp_g)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_%0d got=%h valid=%b want=%h", i, gcd, out_valid, exp_g);
      end
      if (i == 99) begin
        retire();
      end else begin
        na = 16'($urandom_range(0, 65535));
        nb = 16'($urandom_range(0, 65535));
        if (i % 13 == 5) na = 16'd0;
        if (i % 7 == 3) nb = na;
        if (i % 11 == 2) begin
          na = na << 3;
          nb = nb << 5;
        end
        exp_g = ref_gcd(na, nb);
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = na;
        b = nb;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_bubble_%0d got ready=%b valid=%b want 1/0", i, in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_accept_%0d got ready=%b want 0", i, in_ready);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_operand();
    test_boundaries();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
